submatrix_writer: RTL
=====================

SUBMATRIX_WRITER -- requirements
Module: submatrix_writer

Interface
REQ-001 Parameter WORD_WIDTH, default 16: pixels per submatrix word.
REQ-002 Parameter ADDRESS_WIDTH, default 16: width of the image RAM write address.
REQ-003 Parameter FRAME_PIXELS, default 19200 (160x120): pixels per frame; the address wraps at this value.
REQ-004 clock  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 userEnable  in  1  when high, writing advances; when low, writing stalls.
REQ-007 loaded  in  1  upstream word valid.
REQ-008 submatrixElements  in  WORD_WIDTH  upstream grouped pixels; bit WORD_WIDTH-1 is the first pixel.
REQ-009 readyToBeLoaded  out  1  the block can accept a word this cycle.
REQ-010 writeAddress  out  ADDRESS_WIDTH  image RAM write address.
REQ-011 writeData  out  1  pixel to write.
REQ-012 writeEnable  out  1  image RAM write strobe.
REQ-013 frameDone  out  1  one-cycle pulse coinciding with the write of pixel FRAME_PIXELS-1.

Function
REQ-014 Transfer rule: a word is accepted only at a rising edge where loaded=1 and readyToBeLoaded=1.
REQ-015 Storage: two word registers, a shifter and a holding buffer; readyToBeLoaded = NOT bufferFull, independent of loaded (no combinational path).
REQ-016 FSM states: IDLE (shifter empty), WRITE (shifter holds a word).
REQ-017 IDLE -> WRITE on accept; the word loads directly into the shifter, and writeEnable=1 with the first pixel in the next cycle.
REQ-018 In WRITE with userEnable=1, each cycle: writeEnable=1, writeData = current MSB, writeAddress = pixel counter; then shift left and increment the counter.
REQ-019 In WRITE with userEnable=0: writeEnable=0; shifter, bit index, address and buffer all hold.
REQ-020 An accept in WRITE stores the word in the holding buffer and sets bufferFull.
REQ-021 On the 16th pixel of a word with bufferFull=1: buffer moves to the shifter, bufferFull clears, and the state stays WRITE with no idle cycle between words.
REQ-022 On the 16th pixel of a word with bufferFull=0 and no accept that edge: go to IDLE.
REQ-023 On the 16th pixel with an accept at the same edge and bufferFull=0: the word goes straight into the shifter (no bubble).
REQ-024 Sustained throughput: one pixel per enabled cycle; one word per 16 enabled cycles.
REQ-025 Pixel counter wrap: increments modulo FRAME_PIXELS; after FRAME_PIXELS-1 it returns to 0.
REQ-026 frameDone asserts in the same cycle as the write of address FRAME_PIXELS-1.
REQ-027 writeAddress, writeData and writeEnable are registered outputs; writeEnable=0 whenever the state is IDLE.
REQ-028 FRAME_PIXELS need not be a multiple of WORD_WIDTH; a wrap mid-word continues the word at address 0.

Reset
REQ-029 reset asynchronously forces: state IDLE, bufferFull=0, shifter=0, bit index=0, counter=0, writeEnable=0, writeData=0, writeAddress=0, frameDone=0.
REQ-030 readyToBeLoaded=1 after reset.
REQ-031 Reset mid-word discards the shifter and buffer contents; no partial write completes.
REQ-032 After reset release, the first accepted word writes starting at address 0.

Structure
REQ-033 Shared package submatrix_pkg holds WORD_WIDTH, ADDRESS_WIDTH, FRAME_PIXELS defaults and the IDLE/WRITE state encoding; the package is shared with the generator side.
REQ-034 One sub-module, pixel_address_counter: enable input, modulo FRAME_PIXELS, and a terminal-count output that drives frameDone.

Verification
REQ-035 Single word: reset, userEnable=1, loaded=1 with 16'hA5C3 for one cycle -> 16 consecutive writes to addresses 0..15 with data 1010_0101_1100_0011, then IDLE.
REQ-036 Back-to-back: loaded held high with 16'hFFFF then 16'h0000 -> 32 contiguous writeEnable cycles, addresses 0..31, readyToBeLoaded=0 while the buffer is full.
REQ-037 Stall: userEnable=0 for 5 cycles after pixel 3 -> writeEnable=0 for those 5 cycles; resume at address 4 with correct data; total writes still 16.
REQ-038 Wrap: FRAME_PIXELS=40, three words streamed -> frameDone high exactly at the write of address 39; the third word writes addresses 32..39 then continues at 0..7.
REQ-039 Mid-word reset: assert reset at pixel 7 -> all outputs 0 asynchronously, readyToBeLoaded=1; the next word writes from address 0.
REQ-040 Buffer full: loaded held high with shifter busy and buffer full -> no accept, the word is held upstream, and is accepted on the edge the buffer drains.

Source files
------------

// File: rtl/submatrix_pkg.sv
// Shared definitions for the submatrix writer and the generator side.
package submatrix_pkg;

    localparam int WORD_WIDTH_DEF    = 16;
    localparam int ADDRESS_WIDTH_DEF = 16;
    localparam int FRAME_PIXELS_DEF  = 19200;   // 160 x 120

    // IDLE: shifter empty. WRITE: shifter holds unwritten pixels of a word.
    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/pixel_address_counter.sv
// Frame pixel address counter, modulo FRAME_PIXELS, with terminal-count flag.
module pixel_address_counter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int FRAME_PIXELS  = 19200
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    output logic [ADDRESS_WIDTH-1:0] count,
    output logic                     terminal
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(FRAME_PIXELS - 1);

    logic [ADDRESS_WIDTH-1:0] count_q, count_d;

    assign count    = count_q;
    assign terminal = (count_q == LAST);

    // Advance once per written pixel, wrapping after the last pixel of the frame.
    always_comb begin
        count_d = count_q;
        if (enable) count_d = terminal ? '0 : count_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/submatrix_writer.sv
// Serialises grouped pixel words into single-pixel image RAM writes.
// A shifter streams the current word MSB first; one holding buffer lets the
// next word arrive early so consecutive words are written with no gap.
module submatrix_writer
    import submatrix_pkg::*;
#(
    parameter int WORD_WIDTH    = WORD_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int FRAME_PIXELS  = FRAME_PIXELS_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     userEnable,
    input  logic                     loaded,
    input  logic [WORD_WIDTH-1:0]    submatrixElements,
    output logic                     readyToBeLoaded,
    output logic [ADDRESS_WIDTH-1:0] writeAddress,
    output logic                     writeData,
    output logic                     writeEnable,
    output logic                     frameDone
);

    localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_WIDTH - 1);

    wr_state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0]    shift_q, shift_d;
    logic [WORD_WIDTH-1:0]    buf_q, buf_d;
    logic                     buf_full_q, buf_full_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     we_q, we_d;
    logic                     wd_q, wd_d;
    logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
    logic                     fd_q, fd_d;

    logic                     accept;
    logic                     emit;
    logic [ADDRESS_WIDTH-1:0] pix_cnt;
    logic                     pix_last;

    // Ready depends only on the buffer flag, never on loaded.
    assign readyToBeLoaded = ~buf_full_q;
    assign accept          = loaded & ~buf_full_q;

    assign writeAddress = wa_q;
    assign writeData    = wd_q;
    assign writeEnable  = we_q;
    assign frameDone    = fd_q;

    pixel_address_counter #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .FRAME_PIXELS  (FRAME_PIXELS)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .enable   (emit),
        .count    (pix_cnt),
        .terminal (pix_last)
    );

    // Next state: word loading, pixel emission, buffer refill of the shifter.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        idx_d      = idx_q;
        emit       = 1'b0;
        wd_d       = wd_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WRITE;
                    if (userEnable) begin
                        // First pixel goes out on the accepting edge itself.
                        emit    = 1'b1;
                        wd_d    = submatrixElements[WORD_WIDTH-1];
                        shift_d = submatrixElements << 1;
                        idx_d   = IW'(1);
                    end else begin
                        shift_d = submatrixElements;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                if (userEnable) begin
                    emit    = 1'b1;
                    wd_d    = shift_q[WORD_WIDTH-1];
                    shift_d = shift_q << 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (buf_full_q) begin
                            shift_d    = buf_q;
                            buf_full_d = 1'b0;
                        end else if (accept) begin
                            shift_d = submatrixElements;
                        end else begin
                            state_d = IDLE;
                            shift_d = '0;
                        end
                    end else if (accept) begin
                        buf_d      = submatrixElements;
                        buf_full_d = 1'b1;
                    end
                end else if (accept) begin
                    // Stalled: the shifter holds, but an offered word may still park.
                    buf_d      = submatrixElements;
                    buf_full_d = 1'b1;
                end
            end
        endcase
        we_d = emit;
        wa_d = emit ? pix_cnt : wa_q;
        fd_d = emit & pix_last;
    end

    // State and registered RAM-side outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            wd_q       <= 1'b0;
            wa_q       <= '0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            wd_q       <= wd_d;
            wa_q       <= wa_d;
            fd_q       <= fd_d;
        end
    end

endmodule
